// File: rtl/sampler_pkg.sv
// sampler_pkg: constants shared by the sampling front end and the trigger
// stages. GRP_W is the channel-group granularity used by group disable.
package sampler_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam int SUMP_DIV_W    = 24;
  localparam int GRP_W         = 8;
endpackage

// File: rtl/sampler_if.sv
// sampler_if: control/data bundle between the SUMP command decoder and the
// sampler. The master side drives the controls and the raw probes. The
// slave (sampler) side returns the sample word and strobe.
interface sampler_if #(
  parameter int WIDTH = 32,
  parameter int DIV_W = 24
);
  logic                 en_i;
  logic [DIV_W-1:0]     div_i;
  logic                 div_stb_i;
  logic                 test_i;
  logic [WIDTH/8-1:0]   grp_dis_i;
  logic [WIDTH-1:0]     data_i;
  logic [WIDTH-1:0]     smpl_o;
  logic                 stb_o;

  modport master (
    output en_i, div_i, div_stb_i, test_i, grp_dis_i, data_i,
    input  smpl_o, stb_o
  );
  modport slave (
    input  en_i, div_i, div_stb_i, test_i, grp_dis_i, data_i,
    output smpl_o, stb_o
  );
endinterface

// File: rtl/sampler_sync_ff.sv
// sync_ff: two-flop synchronizer for a bus of asynchronous inputs.
// Ports: clk_i/rst_in (async active-low), d_i raw input, q_o synchronized.
// Each bit is synchronized independently. Multi-bit coherence is not
// guaranteed, which is acceptable for independent probe channels.
module sync_ff #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;
endmodule

// File: rtl/sampler.sv
// sampler: synchronizes probes and divides clk_i into a sample strobe
// (rate f_clk/(div+1)). It applies per-byte group disable and an optional
// counter test pattern.
// Ports: clk_i, rst_in (async active-low), bus (sampler_if.slave):
//   en_i, div_i/div_stb_i, test_i, grp_dis_i, data_i -> smpl_o, stb_o.
// smpl_o is valid only while stb_o is high, and holds between strobes.
module sampler
  import sampler_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIV_W = SUMP_DIV_W
) (
  input  logic    clk_i,
  input  logic    rst_in,
  sampler_if.slave bus
);
  localparam int NGRP = WIDTH / GRP_W;

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_src;
  logic [WIDTH-1:0] w_word;
  logic             w_fire;

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_tcnt;
  logic [WIDTH-1:0] r_smpl;
  logic             r_stb;

  sync_ff #(.WIDTH(WIDTH)) u_sync (
    .clk_i  (clk_i),
    .rst_in (rst_in),
    .d_i    (bus.data_i),
    .q_o    (w_sync)
  );

  // Strobe event: enabled and the counter has expired.
  assign w_fire = bus.en_i && (r_cnt == '0);

  // Test pattern uses the pre-increment counter, so the first sample is 0.
  assign w_src = bus.test_i ? r_tcnt : w_sync;

  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    assign w_word[g*GRP_W +: GRP_W] =
      bus.grp_dis_i[g] ? '0 : w_src[g*GRP_W +: GRP_W];
  end

  // The divider register loads independently of en_i.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in)            r_div <= '0;
    else if (bus.div_stb_i) r_div <= bus.div_i;
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_cnt  <= '0;
      r_tcnt <= '0;
      r_smpl <= '0;
      r_stb  <= 1'b0;
    end else if (!bus.en_i) begin
      r_cnt  <= '0;
      r_tcnt <= '0;
      r_stb  <= 1'b0;
    end else if (w_fire) begin
      // A same-cycle load takes effect for the period starting now.
      r_cnt  <= bus.div_stb_i ? bus.div_i : r_div;
      r_tcnt <= r_tcnt + WIDTH'(1);
      r_smpl <= w_word;
      r_stb  <= 1'b1;
    end else begin
      // A mid-period load aborts the current period so the new rate starts
      // with a strobe on the very next cycle.
      r_cnt  <= bus.div_stb_i ? '0 : r_cnt - DIV_W'(1);
      r_stb  <= 1'b0;
    end
  end

  assign bus.smpl_o = r_smpl;
  assign bus.stb_o  = r_stb;
endmodule
